// File: rtl/axi_csr_pkg.sv
// Shared AXI response codes, response merge priority and FSM state types for the CSR slave.
// Imported by the decoder and the slave top.
package axi_csr_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         rd_state_e;

    function automatic logic [1:0] resp_merge(input logic [1:0] a, input logic [1:0] b);
        if (a == RESP_DECERR || b == RESP_DECERR) return RESP_DECERR;
        if (a == RESP_SLVERR || b == RESP_SLVERR) return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

    function automatic logic [31:0] beat_step(input logic [3:0] size);
        return 32'd1 << size;
    endfunction

endpackage

// File: rtl/axi_csr_slave_if.sv
// AXI4 channel bundle between the CPU core master port and the CSR slave.
// Plain signal grouping; no logic.
interface axi_csr_slave_if;
    logic [31:0]  AWADDR;
    logic [7:0]   AWID;
    logic [3:0]   AWSIZE;
    logic [3:0]   AWLEN;
    logic         AWVALID;
    logic         AWREADY;
    logic [31:0]  ARADDR;
    logic [7:0]   ARID;
    logic [3:0]   ARSIZE;
    logic [3:0]   ARLEN;
    logic         ARVALID;
    logic         ARREADY;
    logic [127:0] WDATA;
    logic [15:0]  WSTRB;
    logic         WLAST;
    logic         WVALID;
    logic         WREADY;
    logic [7:0]   BID;
    logic [1:0]   BRESP;
    logic         BVALID;
    logic         BREADY;
    logic [7:0]   RID;
    logic [127:0] RDATA;
    logic [1:0]   RRESP;
    logic         RLAST;
    logic         RVALID;
    logic         RREADY;

    modport slave (
        input  AWADDR, AWID, AWSIZE, AWLEN, AWVALID,
        output AWREADY,
        input  ARADDR, ARID, ARSIZE, ARLEN, ARVALID,
        output ARREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY
    );

    modport master (
        output AWADDR, AWID, AWSIZE, AWLEN, AWVALID,
        input  AWREADY,
        output ARADDR, ARID, ARSIZE, ARLEN, ARVALID,
        input  ARREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );
endinterface

// File: rtl/axi_csr_addr_dec.sv
// Beat decoder: entry index, window hit and beat response; purely combinational, no latency.
// No backpressure of its own.
module axi_csr_addr_dec
    import axi_csr_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          DEPTH     = 16,
    localparam int         IDXW      = $clog2(DEPTH)
) (
    input  logic [31:0]     addr_i,
    input  logic [3:0]      size_i,
    output logic [IDXW-1:0] idx_o,
    output logic            in_win_o,
    output logic [1:0]      resp_o
);

    // BASE_ADDR is window-aligned, so a tag compare of the bits above the index is exact.
    assign idx_o    = addr_i[IDXW+3:4];
    assign in_win_o = (addr_i[31:IDXW+4] == BASE_ADDR[31:IDXW+4]);

    always_comb begin
        resp_o = RESP_OKAY;
        if (size_i > 4'd4) resp_o = RESP_SLVERR;
        if (!in_win_o)     resp_o = RESP_DECERR;
    end

    logic unused_lsb;
    assign unused_lsb = ^addr_i[3:0];

endmodule

// File: rtl/axi_csr_slave.sv
// 128-bit AXI CSR bank slave; B one cycle after last W, R one cycle after AR, then 1 beat/cycle.
// Holds B and R outputs stable until BREADY/RREADY; AW/AR only accepted while the channel is idle.
module axi_csr_slave
    import axi_csr_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          DEPTH     = 16
) (
    input  logic           csr_slv_ACLK,
    input  logic           csr_slv_ARESETn,
    axi_csr_slave_if.slave csr_slv,
    input  logic           err_clr,
    output logic           err_irq,
    output logic [7:0]     err_cnt
);
    localparam int IDXW = $clog2(DEPTH);

    logic         rdy_q;
    logic [127:0] bank_q [DEPTH];

    wr_state_e       w_state_q, w_state_d;
    logic [7:0]      wid_q;
    logic [31:0]     waddr_q;
    logic [3:0]      wlen_q, wsize_q, wbeat_q;
    logic [1:0]      wresp_q, w_dec_resp, w_beat_resp;
    logic [IDXW-1:0] w_idx;
    logic            w_in_win, aw_hs, w_hs, b_hs, w_last_beat;

    rd_state_e       r_state_q, r_state_d;
    logic [7:0]      rid_q;
    logic [31:0]     raddr_q, r_addr;
    logic [3:0]      rlen_q, rsize_q, rbeat_q, r_size;
    logic [127:0]    rdata_q, r_rd_data;
    logic [1:0]      rresp_q, r_dec_resp;
    logic            rlast_q, r_in_win, ar_hs, r_hs, r_load;
    logic [IDXW-1:0] r_idx;

    logic            err_irq_q, b_err, r_err;
    logic [7:0]      err_cnt_q;
    logic [8:0]      err_sum;

    // Keeps AWREADY/ARREADY low while reset is asserted.
    always_ff @(posedge csr_slv_ACLK or negedge csr_slv_ARESETn) begin
        if (!csr_slv_ARESETn) rdy_q <= 1'b0;
        else                  rdy_q <= 1'b1;
    end

    assign aw_hs       = csr_slv.AWVALID && csr_slv.AWREADY;
    assign w_hs        = csr_slv.WVALID && csr_slv.WREADY;
    assign b_hs        = csr_slv.BVALID && csr_slv.BREADY;
    assign w_last_beat = (wbeat_q == wlen_q);
    assign w_beat_resp = resp_merge(w_dec_resp,
                                    (csr_slv.WLAST != w_last_beat) ? RESP_SLVERR : RESP_OKAY);

    axi_csr_addr_dec #(.BASE_ADDR(BASE_ADDR), .DEPTH(DEPTH)) u_wdec (
        .addr_i(waddr_q), .size_i(wsize_q), .idx_o(w_idx), .in_win_o(w_in_win), .resp_o(w_dec_resp)
    );

    always_ff @(posedge csr_slv_ACLK or negedge csr_slv_ARESETn) begin
        if (!csr_slv_ARESETn) w_state_q <= W_IDLE;
        else                  w_state_q <= w_state_d;
    end

    always_comb begin
        w_state_d       = w_state_q;
        csr_slv.AWREADY = 1'b0;
        csr_slv.WREADY  = 1'b0;
        csr_slv.BVALID  = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                csr_slv.AWREADY = rdy_q;
                if (csr_slv.AWVALID && rdy_q) w_state_d = W_DATA;
            end
            W_DATA: begin
                csr_slv.WREADY = 1'b1;
                if (csr_slv.WVALID && w_last_beat) w_state_d = W_RESP;
            end
            W_RESP: begin
                csr_slv.BVALID = 1'b1;
                if (csr_slv.BREADY) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge csr_slv_ACLK or negedge csr_slv_ARESETn) begin
        if (!csr_slv_ARESETn) begin
            wid_q   <= '0;
            waddr_q <= '0;
            wlen_q  <= '0;
            wsize_q <= '0;
            wbeat_q <= '0;
            wresp_q <= RESP_OKAY;
        end else if (aw_hs) begin
            wid_q   <= csr_slv.AWID;
            waddr_q <= csr_slv.AWADDR;
            wlen_q  <= csr_slv.AWLEN;
            wsize_q <= csr_slv.AWSIZE;
            wbeat_q <= '0;
            wresp_q <= RESP_OKAY;
        end else if (w_hs) begin
            waddr_q <= waddr_q + beat_step(wsize_q);
            wbeat_q <= wbeat_q + 4'd1;
            wresp_q <= resp_merge(wresp_q, w_beat_resp);
        end
    end

    // Only a decode failure drops the write; a WLAST mismatch still lands the data.
    always_ff @(posedge csr_slv_ACLK or negedge csr_slv_ARESETn) begin
        if (!csr_slv_ARESETn) begin
            for (int i = 0; i < DEPTH; i++) bank_q[i] <= '0;
        end else if (w_hs && w_dec_resp == RESP_OKAY) begin
            for (int b = 0; b < 16; b++)
                if (csr_slv.WSTRB[b]) bank_q[w_idx][8*b +: 8] <= csr_slv.WDATA[8*b +: 8];
        end
    end

    assign csr_slv.BID   = wid_q;
    assign csr_slv.BRESP = wresp_q;

    assign ar_hs     = csr_slv.ARVALID && csr_slv.ARREADY;
    assign r_hs      = csr_slv.RVALID && csr_slv.RREADY;
    assign r_load    = ar_hs || (r_hs && !rlast_q);
    assign r_addr    = (r_state_q == R_IDLE) ? csr_slv.ARADDR : raddr_q + beat_step(rsize_q);
    assign r_size    = (r_state_q == R_IDLE) ? csr_slv.ARSIZE : rsize_q;
    assign r_rd_data = (r_dec_resp == RESP_OKAY) ? bank_q[r_idx] : '0;

    axi_csr_addr_dec #(.BASE_ADDR(BASE_ADDR), .DEPTH(DEPTH)) u_rdec (
        .addr_i(r_addr), .size_i(r_size), .idx_o(r_idx), .in_win_o(r_in_win), .resp_o(r_dec_resp)
    );

    always_ff @(posedge csr_slv_ACLK or negedge csr_slv_ARESETn) begin
        if (!csr_slv_ARESETn) r_state_q <= R_IDLE;
        else                  r_state_q <= r_state_d;
    end

    always_comb begin
        r_state_d       = r_state_q;
        csr_slv.ARREADY = 1'b0;
        csr_slv.RVALID  = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                csr_slv.ARREADY = rdy_q;
                if (csr_slv.ARVALID && rdy_q) r_state_d = R_DATA;
            end
            R_DATA: begin
                csr_slv.RVALID = 1'b1;
                if (csr_slv.RREADY && rlast_q) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge csr_slv_ACLK or negedge csr_slv_ARESETn) begin
        if (!csr_slv_ARESETn) begin
            rid_q   <= '0;
            rlen_q  <= '0;
            rsize_q <= '0;
            rbeat_q <= '0;
            rlast_q <= 1'b0;
            raddr_q <= '0;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else begin
            if (ar_hs) begin
                rid_q   <= csr_slv.ARID;
                rlen_q  <= csr_slv.ARLEN;
                rsize_q <= csr_slv.ARSIZE;
                rbeat_q <= '0;
                rlast_q <= (csr_slv.ARLEN == 4'd0);
            end else if (r_hs && !rlast_q) begin
                rbeat_q <= rbeat_q + 4'd1;
                rlast_q <= ((rbeat_q + 4'd1) == rlen_q);
            end
            if (r_load) begin
                raddr_q <= r_addr;
                rdata_q <= r_rd_data;
                rresp_q <= r_dec_resp;
            end
        end
    end

    assign csr_slv.RID   = rid_q;
    assign csr_slv.RDATA = rdata_q;
    assign csr_slv.RRESP = rresp_q;
    assign csr_slv.RLAST = rlast_q;

    // A B error and an R error in the same cycle count as two events.
    assign b_err   = b_hs && (csr_slv.BRESP != RESP_OKAY);
    assign r_err   = r_hs && (csr_slv.RRESP != RESP_OKAY);
    assign err_sum = {1'b0, err_cnt_q} + {8'd0, b_err} + {8'd0, r_err};

    always_ff @(posedge csr_slv_ACLK or negedge csr_slv_ARESETn) begin
        if (!csr_slv_ARESETn) begin
            err_irq_q <= 1'b0;
            err_cnt_q <= '0;
        end else if (err_clr) begin
            err_irq_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            if (b_err || r_err) err_irq_q <= 1'b1;
            err_cnt_q <= err_sum[8] ? 8'hFF : err_sum[7:0];
        end
    end

    assign err_irq = err_irq_q;
    assign err_cnt = err_cnt_q;

    logic unused_win;
    assign unused_win = w_in_win ^ r_in_win;

endmodule

// File: tb/tb_axi_csr_slave.sv
// Directed bench for axi_csr_slave: vector table of bursts plus hand sequences for
// concurrency, error counter saturation/clear and mid-burst reset.
module tb_axi_csr_slave;
    import axi_csr_pkg::*;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b1;
    logic       err_clr = 1'b0;
    logic       err_irq;
    logic [7:0] err_cnt;
    int         checks  = 0;
    int         errors  = 0;

    axi_csr_slave_if csr_if();

    axi_csr_slave #(.BASE_ADDR(32'h4000_0000), .DEPTH(16)) dut (
        .csr_slv_ACLK   (clk),
        .csr_slv_ARESETn(rst_n),
        .csr_slv        (csr_if),
        .err_clr        (err_clr),
        .err_irq        (err_irq),
        .err_cnt        (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit                 wr;
        logic [31:0]        addr;
        logic [3:0]         len;
        logic [3:0]         size;
        logic [15:0]        strb;
        int                 wlast_at;
        logic [127:0]       wdata0;
        logic [1:0]         bresp;
        logic [3:0][127:0]  rdata;
        logic [3:0][1:0]    rresp;
        bit                 toggle;
        int                 err;
    } vec_t;

    vec_t vecs [12];

    function automatic vec_t wv(input logic [31:0] a, input logic [3:0] len, input logic [3:0] size,
                                input logic [15:0] strb, input int wlast_at, input logic [127:0] d0,
                                input logic [1:0] bresp, input int err);
        vec_t v;
        v.wr = 1'b1; v.addr = a; v.len = len; v.size = size; v.strb = strb;
        v.wlast_at = wlast_at; v.wdata0 = d0; v.bresp = bresp;
        v.rdata = '0; v.rresp = '0; v.toggle = 1'b0; v.err = err;
        return v;
    endfunction

    function automatic vec_t rv(input logic [31:0] a, input logic [3:0] len, input logic [3:0] size,
                                input logic [127:0] d0, input logic [127:0] d1,
                                input logic [127:0] d2, input logic [127:0] d3,
                                input logic [1:0] r0, input logic [1:0] r1,
                                input logic [1:0] r2, input logic [1:0] r3,
                                input bit tog, input int err);
        vec_t v;
        v.wr = 1'b0; v.addr = a; v.len = len; v.size = size; v.strb = '0;
        v.wlast_at = -1; v.wdata0 = '0; v.bresp = '0;
        v.rdata = {d3, d2, d1, d0}; v.rresp = {r3, r2, r1, r0}; v.toggle = tog; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_write(input vec_t v, input logic [7:0] id);
        int g;
        csr_if.AWADDR  = v.addr;
        csr_if.AWLEN   = v.len;
        csr_if.AWSIZE  = v.size;
        csr_if.AWID    = id;
        csr_if.AWVALID = 1'b1;
        csr_if.WDATA   = v.wdata0;
        csr_if.WSTRB   = v.strb;
        csr_if.WLAST   = 1'b0;
        csr_if.WVALID  = 1'b1;
        chk("w_blocked_before_aw", csr_if.WREADY, 1'b0);
        g = 0;
        while (!csr_if.AWREADY && g < 20) begin step(); g++; end
        chk("aw_ready", csr_if.AWREADY, 1'b1);
        step();
        csr_if.AWVALID = 1'b0;
        for (int k = 0; k <= int'(v.len); k++) begin
            csr_if.WDATA  = v.wdata0 + 128'(k);
            csr_if.WLAST  = (v.wlast_at < 0) ? (k == int'(v.len)) : (k == v.wlast_at);
            csr_if.WVALID = 1'b1;
            g = 0;
            while (!csr_if.WREADY && g < 20) begin step(); g++; end
            chk("w_ready", csr_if.WREADY, 1'b1);
            step();
        end
        csr_if.WVALID = 1'b0;
        csr_if.WLAST  = 1'b0;
        chk("b_latency", csr_if.BVALID, 1'b1);
        chk("bresp", csr_if.BRESP, v.bresp);
        chk("bid", csr_if.BID, id);
        step();
        chk("b_hold_valid", csr_if.BVALID, 1'b1);
        chk("b_hold_resp", csr_if.BRESP, v.bresp);
        csr_if.BREADY = 1'b1;
        step();
        csr_if.BREADY = 1'b0;
        chk("b_done", csr_if.BVALID, 1'b0);
    endtask

    task automatic do_read(input vec_t v, input logic [7:0] id);
        int g;
        logic [127:0] snap_d;
        logic [1:0]   snap_r;
        logic         snap_l;
        csr_if.ARADDR  = v.addr;
        csr_if.ARLEN   = v.len;
        csr_if.ARSIZE  = v.size;
        csr_if.ARID    = id;
        csr_if.ARVALID = 1'b1;
        csr_if.RREADY  = 1'b0;
        g = 0;
        while (!csr_if.ARREADY && g < 20) begin step(); g++; end
        chk("ar_ready", csr_if.ARREADY, 1'b1);
        step();
        csr_if.ARVALID = 1'b0;
        chk("r_latency", csr_if.RVALID, 1'b1);
        for (int k = 0; k <= int'(v.len); k++) begin
            if (v.toggle) begin
                csr_if.RREADY = 1'b0;
                snap_d = csr_if.RDATA;
                snap_r = csr_if.RRESP;
                snap_l = csr_if.RLAST;
                step();
                chk("r_hold_valid", csr_if.RVALID, 1'b1);
                chk("r_hold_data", csr_if.RDATA, snap_d);
                chk("r_hold_resp", csr_if.RRESP, snap_r);
                chk("r_hold_last", csr_if.RLAST, snap_l);
            end
            csr_if.RREADY = 1'b1;
            chk("rvalid", csr_if.RVALID, 1'b1);
            chk("rdata", csr_if.RDATA, v.rdata[k]);
            chk("rresp", csr_if.RRESP, v.rresp[k]);
            chk("rlast", csr_if.RLAST, k == int'(v.len));
            chk("rid", csr_if.RID, id);
            step();
        end
        csr_if.RREADY = 1'b0;
        chk("r_done", csr_if.RVALID, 1'b0);
    endtask

    task automatic run_vec(input vec_t v, input logic [7:0] id);
        if (v.wr) do_write(v, id);
        else      do_read(v, id);
        chk("err_cnt", err_cnt, 128'(v.err));
        chk("err_irq", err_irq, v.err != 0);
    endtask

    task automatic quick_read(input logic [31:0] a, input logic [3:0] len, input logic [3:0] size);
        int g;
        csr_if.ARADDR  = a;
        csr_if.ARLEN   = len;
        csr_if.ARSIZE  = size;
        csr_if.ARID    = 8'hEE;
        csr_if.ARVALID = 1'b1;
        csr_if.RREADY  = 1'b1;
        g = 0;
        while (!csr_if.ARREADY && g < 20) begin step(); g++; end
        step();
        csr_if.ARVALID = 1'b0;
        g = 0;
        while (!(csr_if.RVALID && csr_if.RLAST) && g < 40) begin step(); g++; end
        chk("qr_last_seen", csr_if.RVALID && csr_if.RLAST, 1'b1);
        step();
        csr_if.RREADY = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] a5;
        logic [127:0] e1;
        a5 = {16{8'hA5}};
        e1 = {{12{8'hA5}}, 32'h2};

        vecs[0]  = wv(32'h4000_0010, 4'd0, 4'd4, 16'hFFFF, -1, a5, RESP_OKAY, 0);
        vecs[1]  = rv(32'h4000_0010, 4'd0, 4'd4, a5, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 0);
        vecs[2]  = wv(32'h4000_0000, 4'd3, 4'd4, 16'h000F, -1, 128'h1, RESP_OKAY, 0);
        vecs[3]  = rv(32'h4000_0000, 4'd3, 4'd4, 128'h1, e1, 128'h3, 128'h4,
                      2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 0);
        vecs[4]  = wv(32'h4000_00F0, 4'd1, 4'd4, 16'hFFFF, -1, 128'h1111, RESP_DECERR, 1);
        vecs[5]  = rv(32'h4000_00F0, 4'd0, 4'd4, 128'h1111, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1);
        vecs[6]  = wv(32'h4000_0080, 4'd2, 4'd4, 16'hFFFF, 0, 128'h7, RESP_SLVERR, 2);
        vecs[7]  = rv(32'h4000_0000, 4'd1, 4'd5, 0, 0, 0, 0,
                      RESP_SLVERR, RESP_SLVERR, 2'd0, 2'd0, 1'b0, 4);
        vecs[8]  = rv(32'h4000_00F0, 4'd1, 4'd4, 128'h1111, 0, 0, 0,
                      RESP_OKAY, RESP_DECERR, 2'd0, 2'd0, 1'b0, 5);
        vecs[9]  = wv(32'h4000_0030, 4'd1, 4'd2, 16'hFFFF, -1, 128'h10, RESP_OKAY, 5);
        vecs[10] = rv(32'h4000_0030, 4'd0, 4'd4, 128'h11, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 5);
        vecs[11] = rv(32'h3FFF_FFF0, 4'd0, 4'd4, 0, 0, 0, 0,
                      RESP_DECERR, 2'd0, 2'd0, 2'd0, 1'b0, 6);

        csr_if.AWADDR = '0; csr_if.AWID = '0; csr_if.AWSIZE = '0; csr_if.AWLEN = '0; csr_if.AWVALID = 1'b0;
        csr_if.ARADDR = '0; csr_if.ARID = '0; csr_if.ARSIZE = '0; csr_if.ARLEN = '0; csr_if.ARVALID = 1'b0;
        csr_if.WDATA = '0; csr_if.WSTRB = '0; csr_if.WLAST = 1'b0; csr_if.WVALID = 1'b0;
        csr_if.BREADY = 1'b0; csr_if.RREADY = 1'b0;

        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_awready", csr_if.AWREADY, 1'b0);
        chk("rst_arready", csr_if.ARREADY, 1'b0);
        chk("rst_wready", csr_if.WREADY, 1'b0);
        chk("rst_bvalid", csr_if.BVALID, 1'b0);
        chk("rst_rvalid", csr_if.RVALID, 1'b0);
        chk("rst_err_irq", err_irq, 1'b0);
        chk("rst_err_cnt", err_cnt, 8'd0);
        rst_n = 1'b1;
        step();
        chk("post_rst_awready", csr_if.AWREADY, 1'b1);
        chk("post_rst_arready", csr_if.ARREADY, 1'b1);

        for (int i = 0; i < 12; i++) run_vec(vecs[i], 8'(8'h20 + i));

        // Concurrent write and read of entry 2: read sees the pre-write value 3.
        csr_if.AWADDR = 32'h4000_0020; csr_if.AWLEN = 4'd0; csr_if.AWSIZE = 4'd4;
        csr_if.AWID = 8'h77; csr_if.AWVALID = 1'b1;
        chk("cc_awready", csr_if.AWREADY, 1'b1);
        step();
        csr_if.AWVALID = 1'b0;
        csr_if.WDATA = 128'hBEEF; csr_if.WSTRB = 16'hFFFF; csr_if.WLAST = 1'b1; csr_if.WVALID = 1'b1;
        csr_if.ARADDR = 32'h4000_0020; csr_if.ARLEN = 4'd0; csr_if.ARSIZE = 4'd4;
        csr_if.ARID = 8'h55; csr_if.ARVALID = 1'b1;
        chk("cc_wready", csr_if.WREADY, 1'b1);
        chk("cc_arready", csr_if.ARREADY, 1'b1);
        step();
        csr_if.WVALID = 1'b0; csr_if.WLAST = 1'b0; csr_if.ARVALID = 1'b0;
        chk("cc_rvalid", csr_if.RVALID, 1'b1);
        chk("cc_rdata_old", csr_if.RDATA, 128'h3);
        chk("cc_bvalid", csr_if.BVALID, 1'b1);
        chk("cc_bresp", csr_if.BRESP, RESP_OKAY);
        csr_if.RREADY = 1'b1; csr_if.BREADY = 1'b1;
        step();
        csr_if.RREADY = 1'b0; csr_if.BREADY = 1'b0;
        run_vec(rv(32'h4000_0020, 4'd0, 4'd4, 128'hBEEF, 0, 0, 0,
                   2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 6), 8'h56);

        // 17 bursts of 16 SLVERR beats drive the counter past 255.
        for (int i = 0; i < 17; i++) quick_read(32'h4000_0000, 4'd15, 4'd5);
        chk("err_cnt_saturated", err_cnt, 8'd255);
        chk("err_irq_set", err_irq, 1'b1);

        // err_clr coincident with an error beat handshake wins.
        csr_if.ARADDR = 32'h4000_0000; csr_if.ARLEN = 4'd0; csr_if.ARSIZE = 4'd5;
        csr_if.ARID = 8'h44; csr_if.ARVALID = 1'b1;
        step();
        csr_if.ARVALID = 1'b0;
        chk("clr_rresp", csr_if.RRESP, RESP_SLVERR);
        csr_if.RREADY = 1'b1;
        err_clr = 1'b1;
        step();
        csr_if.RREADY = 1'b0;
        err_clr = 1'b0;
        chk("clr_err_irq", err_irq, 1'b0);
        chk("clr_err_cnt", err_cnt, 8'd0);
        chk("clr_rvalid", csr_if.RVALID, 1'b0);

        // Reset while beat 2 of a 4-beat read is presented.
        csr_if.ARADDR = 32'h4000_0000; csr_if.ARLEN = 4'd3; csr_if.ARSIZE = 4'd4;
        csr_if.ARID = 8'h33; csr_if.ARVALID = 1'b1;
        step();
        csr_if.ARVALID = 1'b0;
        csr_if.RREADY = 1'b1;
        step();
        csr_if.RREADY = 1'b0;
        chk("mid_beat2_data", csr_if.RDATA, e1);
        chk("mid_beat2_valid", csr_if.RVALID, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rvalid", csr_if.RVALID, 1'b0);
        chk("mid_rst_rdata", csr_if.RDATA, 128'h0);
        chk("mid_rst_awready", csr_if.AWREADY, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rel_arready", csr_if.ARREADY, 1'b1);
        chk("rel_awready", csr_if.AWREADY, 1'b1);
        chk("rel_bvalid", csr_if.BVALID, 1'b0);
        chk("rel_rvalid", csr_if.RVALID, 1'b0);
        run_vec(rv(32'h4000_0010, 4'd0, 4'd4, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 0), 8'h61);
        run_vec(rv(32'h4000_00F0, 4'd0, 4'd4, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 0), 8'h62);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
